multi_cycle_cpu: RTL

- Parametrised multi-cycle MIPS-subset core; successor to the single-cycle CPU.
- Replaces its combinational fetch-decode-execute path with an FSM that reuses one ALU across cycles.
- Talks to external instruction and data memories through req/rdy handshakes, so it tolerates multi-cycle memories.
- Adds branches, jumps, load/store and an illegal-instruction halt.

---
 rtl/multi_cycle_cpu.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/multi_cycle_cpu.sv
// Multi-cycle MIPS-subset core: a FETCH/DECODE/EXEC/MEM/WB/HALT FSM that reuses one datapath.
// Instruction and data memories are reached through req/rdy handshakes, so any memory latency works.
module multi_cycle_cpu #(
    parameter int                DATA_W   = 32,
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] PC_RESET = '0
) (
    input  logic              clk_i,
    input  logic              rst_n,
    output logic              imem_req_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    input  logic              imem_rdy_i,
    input  logic [31:0]       imem_data_i,
    output logic              dmem_req_o,
    output logic              dmem_we_o,
    output logic [ADDR_W-1:0] dmem_addr_o,
    output logic [DATA_W-1:0] dmem_wdata_o,
    input  logic              dmem_rdy_i,
    input  logic [DATA_W-1:0] dmem_rdata_i,
    output logic              retire_o,
    output logic              halted_o
);
    localparam int SH_W = $clog2(DATA_W);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_SLT  = 6'h2A;

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [31:0]       ir_q, ir_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d, alu_q, alu_d, mdr_q, mdr_d;
    logic [DATA_W-1:0] rf_q [32];

    logic              rf_we;
    logic [4:0]        rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic              imem_req, dmem_req, retire, legal;

    logic [5:0]        opcode, funct;
    logic [4:0]        rs, rt, rd, shamt;
    logic [15:0]       imm;
    logic [DATA_W-1:0] imm_sext, lui_val, r_res;
    logic [ADDR_W-1:0] br_off, jmp_tgt, alu_addr;

    assign opcode   = ir_q[31:26];
    assign rs       = ir_q[25:21];
    assign rt       = ir_q[20:16];
    assign rd       = ir_q[15:11];
    assign shamt    = ir_q[10:6];
    assign funct    = ir_q[5:0];
    assign imm      = ir_q[15:0];
    assign imm_sext = {{(DATA_W-16){imm[15]}}, imm};
    assign lui_val  = imm_sext << 16;
    assign br_off   = {{(ADDR_W-18){imm[15]}}, imm, 2'b00};
    assign jmp_tgt  = {pc_q[ADDR_W-1:28], ir_q[25:0], 2'b00};
    assign alu_addr = ADDR_W'(alu_q);

    always_comb begin
        legal = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_SLL, FN_SRL, FN_SLLV, FN_SRLV, FN_ADD,
                    FN_SUB, FN_AND, FN_OR, FN_SLT: legal = 1'b1;
                    default:                       legal = 1'b0;
                endcase
            end
            OP_J, OP_BEQ, OP_BNE, OP_ADDI, OP_LUI, OP_LW, OP_SW: legal = 1'b1;
            default: legal = 1'b0;
        endcase
    end

    // Variable shifts use only the low log2(DATA_W) bits of A.
    always_comb begin
        r_res = '0;
        case (funct)
            FN_ADD:  r_res = a_q + b_q;
            FN_SUB:  r_res = a_q - b_q;
            FN_AND:  r_res = a_q & b_q;
            FN_OR:   r_res = a_q | b_q;
            FN_SLT:  r_res[0] = $signed(a_q) < $signed(b_q);
            FN_SLL:  r_res = b_q << shamt;
            FN_SRL:  r_res = b_q >> shamt;
            FN_SLLV: r_res = b_q << a_q[SH_W-1:0];
            FN_SRLV: r_res = b_q >> a_q[SH_W-1:0];
            default: r_res = '0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        a_d      = a_q;
        b_d      = b_q;
        alu_d    = alu_q;
        mdr_d    = mdr_q;
        rf_we    = 1'b0;
        rf_waddr = rt;
        rf_wdata = alu_q;
        imem_req = 1'b0;
        dmem_req = 1'b0;
        retire   = 1'b0;
        case (state_q)
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_rdy_i) begin
                    ir_d    = imem_data_i;
                    pc_d    = pc_q + ADDR_W'(4);
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                // PC already points past this instruction, so this is the branch target.
                a_d     = rf_q[rs];
                b_d     = rf_q[rt];
                alu_d   = DATA_W'(pc_q + br_off);
                state_d = legal ? S_EXEC : S_HALT;
            end
            S_EXEC: begin
                case (opcode)
                    OP_RTYPE: begin alu_d = r_res;          state_d = S_WB;  end
                    OP_ADDI:  begin alu_d = a_q + imm_sext; state_d = S_WB;  end
                    OP_LUI:   begin alu_d = lui_val;        state_d = S_WB;  end
                    OP_LW, OP_SW: begin alu_d = a_q + imm_sext; state_d = S_MEM; end
                    OP_BEQ, OP_BNE: begin
                        if ((a_q == b_q) ^ (opcode == OP_BNE)) pc_d = alu_addr;
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end
                    OP_J: begin
                        pc_d    = jmp_tgt;
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end
                    default: state_d = S_HALT;
                endcase
            end
            S_MEM: begin
                dmem_req = 1'b1;
                if (dmem_rdy_i) begin
                    if (opcode == OP_SW) begin
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        mdr_d   = dmem_rdata_i;
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                rf_we    = 1'b1;
                rf_waddr = (opcode == OP_RTYPE) ? rd : rt;
                rf_wdata = (opcode == OP_LW) ? mdr_q : alu_q;
                retire   = 1'b1;
                state_d  = S_FETCH;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            pc_q    <= PC_RESET;
            ir_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            alu_q   <= '0;
            mdr_q   <= '0;
            for (int i = 0; i < 32; i++) rf_q[i] <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            a_q     <= a_d;
            b_q     <= b_d;
            alu_q   <= alu_d;
            mdr_q   <= mdr_d;
            if (rf_we && rf_waddr != 5'd0) rf_q[rf_waddr] <= rf_wdata;
        end
    end

    // Strobes are masked while reset is held so the core is silent until released.
    assign imem_req_o   = imem_req & rst_n;
    assign imem_addr_o  = pc_q;
    assign dmem_req_o   = dmem_req & rst_n;
    assign dmem_we_o    = dmem_req_o & (opcode == OP_SW);
    assign dmem_addr_o  = alu_addr;
    assign dmem_wdata_o = b_q;
    assign retire_o     = retire & rst_n;
    assign halted_o     = (state_q == S_HALT) & rst_n;

endmodule
